// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Unsigned variants exist only for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake between the pipeline stage and the LSU.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_mem_master_load_align.sv
// Shifts the read word down to the addressed byte and sign/zero extends by funct3.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_rdata
);

  logic [31:0] w_x;
  assign w_x = i_mem_data >> {i_off, 3'b000};

  // Extension select; unknown encodings never reach here as a valid response.
  always_comb begin
    o_rdata = w_x;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_x[7]}}, w_x[7:0]};
      F3_BU:   o_rdata = {24'd0, w_x[7:0]};
      F3_H:    o_rdata = {{16{w_x[15]}}, w_x[15:0]};
      F3_HU:   o_rdata = {16'd0, w_x[15:0]};
      default: o_rdata = w_x;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a 1-cycle-read word memory with byte enables.
// One request outstanding: IDLE -> ACCESS -> RESP, errors skip ACCESS.
module lsu_mem_master
  import riscv_lsu_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lsu_mem_master_if.slave   bus,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic              o_mem_rw_mode,
  output logic [31:0]       o_mem_write_data,
  output logic [3:0]        o_mem_byte_en,
  input  logic [31:0]       i_mem_data
);

  lsu_state_t          r_state, w_next;
  logic                r_we, r_err;
  logic [2:0]          r_f3;
  logic [MEM_AW+1:0]   r_addr;
  logic [31:0]         r_wdata;

  logic                w_accept, w_misal, w_oor, w_err;
  logic [1:0]          w_off;
  logic [3:0]          w_be;
  logic [31:0]         w_wd, w_load;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // Request classification is done on the incoming request so errors can skip ACCESS.
  assign w_misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_oor   = (bus.req_addr >> (MEM_AW + 2)) != 32'd0;
  assign w_err   = w_misal || w_oor || !f3_legal(bus.req_we, bus.req_funct3);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Capture the request on acceptance; held until the next accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_err   <= w_err;
      r_f3    <= bus.req_funct3;
      r_addr  <= bus.req_addr[MEM_AW+1:0];
      r_wdata <= bus.req_wdata;
    end
  end

  assign w_off      = r_addr[1:0];
  assign w_wd       = r_wdata << {w_off, 3'b000};
  // Address stays on the port through RESP so the memory keeps returning the same word.
  assign o_mem_addr = r_addr[MEM_AW+1:2];

  // Byte lanes for the registered store size.
  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_be = 4'b0001 << w_off;
      2'b01:   w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
  end

  lsu_load_align u_align (
    .i_off      (w_off),
    .i_funct3   (r_f3),
    .i_mem_data (i_mem_data),
    .o_rdata    (w_load)
  );

  // Next state and outputs; memory writes only in ACCESS for a store.
  always_comb begin
    w_next           = r_state;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_err      = 1'b0;
    bus.rsp_rdata    = '0;
    o_mem_rw_mode    = 1'b1;
    o_mem_byte_en    = '0;
    o_mem_write_data = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = w_err ? RESP : ACCESS;
      end
      ACCESS: begin
        w_next = RESP;
        if (r_we) begin
          o_mem_rw_mode    = 1'b0;
          o_mem_byte_en    = w_be;
          o_mem_write_data = w_wd;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_rdata = (r_we || r_err) ? 32'd0 : w_load;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master paired with a 1-cycle-read byte-enable memory model.
module tb_lsu_mem_master;
  import riscv_lsu_pkg::*;

  localparam int MEM_AW = 10;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rw;
  logic [31:0]       mem_wd;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rd;

  lsu_mem_master_if u_bus();

  lsu_mem_master #(.MEM_AW(MEM_AW)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .bus              (u_bus),
    .o_mem_addr       (mem_addr),
    .o_mem_rw_mode    (mem_rw),
    .o_mem_write_data (mem_wd),
    .o_mem_byte_en    (mem_be),
    .i_mem_data       (mem_rd)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Data memory: writes whenever rw=0, registered read of the current address.
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  bit          mem_init = 1'b0;
  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (!mem_rw) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end
    mem_rd <= mem[mem_addr];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Drive one request, check the memory-cycle outputs, then pop and compare the response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, input int hold);
    exp_t e;
    int   acc;
    int   lat;
    bit   got;
    sb.push_back(exp_t'{rdata: exp_rd, err: exp_err, lat: (exp_err ? 4'd1 : 4'd2)});
    @(negedge i_clk);
    check("req_ready_idle", {31'd0, u_bus.req_ready}, 32'd1);
    u_bus.req_valid  = 1'b1;
    u_bus.req_we     = we;
    u_bus.req_funct3 = f3;
    u_bus.req_addr   = addr;
    u_bus.req_wdata  = wd;
    u_bus.rsp_ready  = (hold == 0);
    @(posedge i_clk);
    #1;
    acc = cyc;
    u_bus.req_valid = 1'b0;
    if (!exp_err && we) begin
      check("acc_addr", {22'd0, mem_addr}, addr >> 2);
      check("acc_rw", {31'd0, mem_rw}, 32'd0);
      check("acc_be", {28'd0, mem_be}, {28'd0, exp_be});
      check("acc_wdata", mem_wd, exp_wd);
    end else begin
      check("acc_rw_rd", {31'd0, mem_rw}, 32'd1);
      check("acc_be_rd", {28'd0, mem_be}, 32'd0);
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (exp_err) check("err_rw", {31'd0, mem_rw}, 32'd1);
      if (u_bus.rsp_valid && lat == 0) lat = cyc - acc + 1;
      if (u_bus.rsp_valid && hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          check("hold_vld", {31'd0, u_bus.rsp_valid}, 32'd1);
          check("hold_req_rdy", {31'd0, u_bus.req_ready}, 32'd0);
          check("hold_rdata", u_bus.rsp_rdata, exp_rd);
          if (h < hold - 1) @(negedge i_clk);
        end
        hold = 0;
        @(posedge i_clk);
        #1 u_bus.rsp_ready = 1'b1;
        @(negedge i_clk);
      end
      if (u_bus.rsp_valid && u_bus.rsp_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        check("rsp_rdata", u_bus.rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, u_bus.rsp_err}, {31'd0, e.err});
        check("rsp_lat", 32'(lat), 32'(e.lat));
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    u_bus.req_valid  = 1'b0;
    u_bus.req_we     = 1'b0;
    u_bus.req_funct3 = '0;
    u_bus.req_addr   = '0;
    u_bus.req_wdata  = '0;
    u_bus.rsp_ready  = 1'b1;
    repeat (3) @(negedge i_clk);

    // Reset state.
    check("rst_req_ready", {31'd0, u_bus.req_ready}, 32'd1);
    check("rst_rw", {31'd0, mem_rw}, 32'd1);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, u_bus.rsp_err}, 32'd0);
    check("rst_rdata", u_bus.rsp_rdata, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wd, 32'd0);
    i_rst = 1'b0;

    // Stores, aligned loads and extension.
    issue(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 0);
    issue(0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0,        0);
    issue(1, F3_B,  32'h13, 32'h000000A5, 32'h0,        0, 4'h8, 32'hA5000000, 0);
    issue(0, F3_B,  32'h13, 32'h0,        32'hFFFFFFA5, 0, 4'h0, 32'h0,        0);
    issue(0, F3_BU, 32'h13, 32'h0,        32'h000000A5, 0, 4'h0, 32'h0,        0);
    issue(0, F3_H,  32'h12, 32'h0,        32'hFFFFA5AD, 0, 4'h0, 32'h0,        0);
    issue(0, F3_HU, 32'h12, 32'h0,        32'h0000A5AD, 0, 4'h0, 32'h0,        0);
    issue(0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, 0, 4'h0, 32'h0,        0);
    issue(0, F3_B,  32'h11, 32'h0,        32'hFFFFFFBE, 0, 4'h0, 32'h0,        0);
    issue(1, F3_H,  32'h12, 32'h00001234, 32'h0,        0, 4'hC, 32'h12340000, 0);
    issue(0, F3_W,  32'h10, 32'h0,        32'h1234BEEF, 0, 4'h0, 32'h0,        0);

    // Top of the address range.
    issue(1, F3_W,  32'hFFC, 32'hCAFEF00D, 32'h0,       0, 4'hF, 32'hCAFEF00D, 0);
    issue(0, F3_W,  32'hFFC, 32'h0,        32'hCAFEF00D, 0, 4'h0, 32'h0,       0);

    // Errors: misaligned, out of range, illegal funct3.
    issue(0, F3_W,   32'h11,   32'h0,        32'h0, 1, 4'h0, 32'h0, 0);
    issue(1, F3_H,   32'h13,   32'hFFFFFFFF, 32'h0, 1, 4'h0, 32'h0, 0);
    issue(0, F3_W,   32'h1000, 32'h0,        32'h0, 1, 4'h0, 32'h0, 0);
    issue(0, 3'b011, 32'h10,   32'h0,        32'h0, 1, 4'h0, 32'h0, 0);
    issue(1, F3_BU,  32'h10,   32'hFFFFFFFF, 32'h0, 1, 4'h0, 32'h0, 0);
    issue(0, F3_HU,  32'h11,   32'h0,        32'h0, 1, 4'h0, 32'h0, 0);
    issue(0, F3_W,   32'h10,   32'h0,        32'h1234BEEF, 0, 4'h0, 32'h0, 0);

    // Response backpressure.
    issue(0, F3_HU, 32'h12, 32'h0, 32'h00001234, 0, 4'h0, 32'h0, 3);

    // Reset during ACCESS of a store: nothing is written.
    @(negedge i_clk);
    u_bus.req_valid  = 1'b1;
    u_bus.req_we     = 1'b1;
    u_bus.req_funct3 = F3_W;
    u_bus.req_addr   = 32'h20;
    u_bus.req_wdata  = 32'h12345678;
    @(posedge i_clk);
    #1;
    u_bus.req_valid = 1'b0;
    check("midrst_acc_rw", {31'd0, mem_rw}, 32'd0);
    i_rst = 1'b1;
    #1;
    check("midrst_rw", {31'd0, mem_rw}, 32'd1);
    check("midrst_be", {28'd0, mem_be}, 32'd0);
    check("midrst_ready", {31'd0, u_bus.req_ready}, 32'd1);
    @(negedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_mem", mem[8], 32'd0);
    check("midrst_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
    issue(0, F3_W, 32'h20, 32'h0, 32'h0, 0, 4'h0, 32'h0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
